alt_vipitc130_is2vid_genlock_sequencer: RTL

//  Sequences genlock for the IS2Vid output path. Gathers line/sample sync-compare results and issues one

---
 rtl/alt_vipitc130_is2vid_genlock_sequencer_pkg.sv | 32 +++
 rtl/alt_vipitc130_is2vid_genlock_sequencer_edge_detect.sv | 22 ++
 rtl/alt_vipitc130_is2vid_genlock_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alt_vipitc130_is2vid_genlock_sequencer_pkg.sv
// Shared definitions for the IS2Vid genlock sequencer: state encodings,
// sync-compare field widths and the registered compare snapshot.
package alt_vipitc130_is2vid_genlock_sequencer_pkg;

   localparam int H_W = 14;
   localparam int V_W = 13;

   // Encodings are visible through the status register, so they are fixed.
   typedef enum logic [2:0] {
      GS_IDLE      = 3'd0,
      GS_SETTLE    = 3'd1,
      GS_EVAL      = 3'd2,
      GS_WAIT_DONE = 3'd3,
      GS_LOCKED    = 3'd4
   } gs_state_t;

   // Compare results captured on the CVO start of frame.
   typedef struct packed {
      logic           lines;
      logic           samples;
      logic           remove;
      logic           genlocked;
      logic [H_W-1:0] h;
      logic [V_W-1:0] v;
   } gs_snap_t;

   // A frame needs a correction when either a line or a sample fix is requested.
   function automatic logic gs_needs_correction(input gs_snap_t s);
      return s.lines | s.samples;
   endfunction

endpackage

// File: rtl/alt_vipitc130_is2vid_genlock_sequencer_edge_detect.sv
// Rising-edge detector: one-cycle pulse in the first cycle a level is seen high.
module alt_vipitc130_common_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_level,
   output logic o_rise
);

   logic r_level_q;

   // Remember the previous level so a held level yields a single pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_level_q <= 1'b0;
      end else begin
         r_level_q <= i_level;
      end
   end

   assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/alt_vipitc130_is2vid_genlock_sequencer.sv
// Genlock sequencer for the IS2Vid output path. Snapshots the sync-compare
// results on each CVO start of frame, issues at most one correction per frame,
// waits for it to finish, and declares lock after consecutive clean frames.
//
// Handshake: o_apply_valid is a one-cycle qualifier with no ready; the apply_*
// fields are meaningful only while it is high (zero otherwise) and the frame
// counter must take them in that cycle. i_correction_done is a one-cycle pulse
// back from the frame counter and is ignored unless a correction is pending.
module alt_vipitc130_is2vid_genlock_sequencer
   import alt_vipitc130_is2vid_genlock_sequencer_pkg::*;
#(
   parameter int SETTLE_FRAMES  = 2,
   parameter int LOCK_FRAMES    = 3,
   parameter int TIMEOUT_FRAMES = 4,
   parameter int FCNT_WIDTH     = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [1:0]     i_genlock_enable,
   input  logic           i_sof_cvi_locked,
   input  logic           i_sof_cvo_locked,
   input  logic           i_sof_cvo,
   input  logic           i_sync_lines,
   input  logic           i_sync_samples,
   input  logic           i_remove_repeatn,
   input  logic [H_W-1:0] i_sync_compare_h_reset,
   input  logic [V_W-1:0] i_sync_compare_v_reset,
   input  logic           i_genlocked,
   input  logic           i_correction_done,
   output logic           o_restart_count,
   output logic           o_apply_valid,
   output logic           o_apply_lines,
   output logic           o_apply_samples,
   output logic           o_apply_remove,
   output logic [H_W-1:0] o_apply_h,
   output logic [V_W-1:0] o_apply_v,
   output logic           o_status_locked,
   output logic           o_lock_lost,
   output logic [2:0]     o_status_state
);

   localparam logic [FCNT_WIDTH-1:0] SETTLE_LAST  = FCNT_WIDTH'(SETTLE_FRAMES - 1);
   localparam logic [FCNT_WIDTH-1:0] LOCK_LAST    = FCNT_WIDTH'(LOCK_FRAMES - 1);
   localparam logic [FCNT_WIDTH-1:0] TIMEOUT_LAST = FCNT_WIDTH'(TIMEOUT_FRAMES - 1);

   logic                  w_en;
   logic                  w_sof;
   logic                  w_corr;
   gs_state_t             r_state;
   gs_state_t             w_state_nxt;
   gs_snap_t              r_snap;
   logic                  r_tick;
   logic [FCNT_WIDTH-1:0] r_cnt;
   logic [FCNT_WIDTH-1:0] w_cnt_nxt;
   logic [FCNT_WIDTH-1:0] r_lock_cnt;
   logic [FCNT_WIDTH-1:0] w_lock_cnt_nxt;
   logic                  w_restart_nxt;
   logic                  w_apply_nxt;
   logic                  w_locked_nxt;
   logic                  w_lost_nxt;
   logic                  r_restart;
   logic                  r_apply_valid;
   logic                  r_apply_lines;
   logic                  r_apply_samples;
   logic                  r_apply_remove;
   logic [H_W-1:0]        r_apply_h;
   logic [V_W-1:0]        r_apply_v;
   logic                  r_locked;
   logic                  r_lost;

   // Both register-map bits and both video paths must be locked to run.
   assign w_en = (i_genlock_enable == 2'b11) & i_sof_cvi_locked & i_sof_cvo_locked;

   alt_vipitc130_common_edge_detect u_sof_edge (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_level (i_sof_cvo),
      .o_rise  (w_sof)
   );

   // Snapshot the compare results on the SOF edge; r_tick marks the cycle the
   // snapshot becomes usable, and all frame counting runs on r_tick.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_snap <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_sof;
         if (w_sof) begin
            r_snap <= '{lines:     i_sync_lines,
                        samples:   i_sync_samples,
                        remove:    i_remove_repeatn,
                        genlocked: i_genlocked,
                        h:         i_sync_compare_h_reset,
                        v:         i_sync_compare_v_reset};
         end
      end
   end

   assign w_corr = gs_needs_correction(r_snap);

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= GS_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; losing enable always drops back to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      if (!w_en) begin
         w_state_nxt = GS_IDLE;
      end else begin
         case (r_state)
            GS_IDLE: begin
               w_state_nxt = GS_SETTLE;
            end
            GS_SETTLE: begin
               if (r_tick && (r_cnt == SETTLE_LAST)) begin
                  w_state_nxt = GS_EVAL;
               end
            end
            GS_EVAL: begin
               if (r_tick) begin
                  if (w_corr) begin
                     w_state_nxt = GS_WAIT_DONE;
                  end else if (r_snap.genlocked && (r_lock_cnt == LOCK_LAST)) begin
                     w_state_nxt = GS_LOCKED;
                  end
               end
            end
            GS_WAIT_DONE: begin
               // Done and timeout both resettle; done simply takes precedence.
               if (i_correction_done) begin
                  w_state_nxt = GS_SETTLE;
               end else if (r_tick && (r_cnt == TIMEOUT_LAST)) begin
                  w_state_nxt = GS_SETTLE;
               end
            end
            GS_LOCKED: begin
               if (r_tick && (!r_snap.genlocked || w_corr)) begin
                  w_state_nxt = GS_EVAL;
               end
            end
            default: begin
               w_state_nxt = GS_IDLE;
            end
         endcase
      end
   end

   // Per-state counter updates and next values of the registered outputs.
   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_lock_cnt_nxt = r_lock_cnt;
      w_restart_nxt  = 1'b0;
      w_apply_nxt    = 1'b0;
      w_locked_nxt   = r_locked;
      w_lost_nxt     = 1'b0;
      if (!w_en) begin
         w_cnt_nxt      = '0;
         w_lock_cnt_nxt = '0;
         w_locked_nxt   = 1'b0;
      end else begin
         case (r_state)
            GS_IDLE: begin
               w_restart_nxt  = 1'b1;
               w_cnt_nxt      = '0;
               w_lock_cnt_nxt = '0;
            end
            GS_SETTLE: begin
               if (r_tick) begin
                  w_cnt_nxt = (r_cnt == SETTLE_LAST) ? '0 : r_cnt + 1'b1;
               end
            end
            GS_EVAL: begin
               if (r_tick) begin
                  if (w_corr) begin
                     w_apply_nxt    = 1'b1;
                     w_cnt_nxt      = '0;
                     w_lock_cnt_nxt = '0;
                  end else if (r_snap.genlocked) begin
                     if (r_lock_cnt == LOCK_LAST) begin
                        w_locked_nxt   = 1'b1;
                        w_lock_cnt_nxt = '0;
                     end else begin
                        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                     end
                  end else begin
                     w_lock_cnt_nxt = '0;
                  end
               end
            end
            GS_WAIT_DONE: begin
               if (i_correction_done) begin
                  w_cnt_nxt = '0;
               end else if (r_tick) begin
                  if (r_cnt == TIMEOUT_LAST) begin
                     w_restart_nxt = 1'b1;
                     w_cnt_nxt     = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end
            end
            GS_LOCKED: begin
               if (r_tick && (!r_snap.genlocked || w_corr)) begin
                  w_locked_nxt   = 1'b0;
                  w_lost_nxt     = 1'b1;
                  w_lock_cnt_nxt = '0;
               end
            end
            default: begin
               w_cnt_nxt      = '0;
               w_lock_cnt_nxt = '0;
               w_locked_nxt   = 1'b0;
            end
         endcase
      end
   end

   // Counters and registered outputs; apply_* carry the snapshot only while valid.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt           <= '0;
         r_lock_cnt      <= '0;
         r_restart       <= 1'b0;
         r_apply_valid   <= 1'b0;
         r_apply_lines   <= 1'b0;
         r_apply_samples <= 1'b0;
         r_apply_remove  <= 1'b0;
         r_apply_h       <= '0;
         r_apply_v       <= '0;
         r_locked        <= 1'b0;
         r_lost          <= 1'b0;
      end else begin
         r_cnt           <= w_cnt_nxt;
         r_lock_cnt      <= w_lock_cnt_nxt;
         r_restart       <= w_restart_nxt;
         r_apply_valid   <= w_apply_nxt;
         r_apply_lines   <= w_apply_nxt & r_snap.lines;
         r_apply_samples <= w_apply_nxt & r_snap.samples;
         r_apply_remove  <= w_apply_nxt & r_snap.remove;
         r_apply_h       <= w_apply_nxt ? r_snap.h : '0;
         r_apply_v       <= w_apply_nxt ? r_snap.v : '0;
         r_locked        <= w_locked_nxt;
         r_lost          <= w_lost_nxt;
      end
   end

   assign o_restart_count = r_restart;
   assign o_apply_valid   = r_apply_valid;
   assign o_apply_lines   = r_apply_lines;
   assign o_apply_samples = r_apply_samples;
   assign o_apply_remove  = r_apply_remove;
   assign o_apply_h       = r_apply_h;
   assign o_apply_v       = r_apply_v;
   assign o_status_locked = r_locked;
   assign o_lock_lost     = r_lost;
   assign o_status_state  = r_state;

endmodule
